dvp_pixel_capture: RTL and testbench
====================================

# dvp_pixel_capture

Parametrised DVP camera capture front end. Samples the raw sensor bus (vsync, href, byte data) in the pixel-clock domain and assembles PIX_BYTES beats into one pixel word. It discards the first SKIP_FRAMES frames after sensor configuration completes, crops to a programmable window, and flags malformed lines. It sits between the camera pins and the frame buffer/UDP packetiser, replacing the fixed 8-bit/RGB565 user-side capture path.

## Interface
- DATA_W, 8: sensor data bus width (8 or 10).
- PIX_BYTES, 2: bus beats per pixel (1 = RAW, 2 = RGB565/YUV422).
- H_ACTIVE, 640: expected pixels per href-high line.
- SKIP_FRAMES, 3: frames discarded after cam_init_done rises (0..15).
- VS_POL, 1: cmos_vsync active level.
- WIN_X0 / WIN_W, 0 / 640: crop column start / width, in pixels.
- WIN_Y0 / WIN_H, 0 / 480: crop row start / height, in lines.

Ports:
- cmos_pclk  in  1  sensor pixel clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- cam_init_done  in  1  sensor register configuration finished (level).
- cmos_vsync  in  1  raw frame sync.
- cmos_href  in  1  raw line valid.
- cmos_db  in  DATA_W  raw data beat.
- vsync  out  1  frame sync, active high, asserted only in RUN.
- de  out  1  one-cycle pixel-valid strobe.
- data  out  DATA_W*PIX_BYTES  packed pixel; first beat in the MSBs.
- pix_x  out  12  column of the current `data` within the crop window.
- pix_y  out  12  row of the current `data` within the crop window.
- frame_cnt  out  16  delivered frames; wraps 0xFFFF→0.
- line_err  out  1  one-cycle pulse on a malformed line.
- err_sticky  out  1  set by line_err; cleared on reset or leaving RUN.

## Operation
- Stage 0 registers cmos_vsync (normalised by VS_POL), cmos_href and cmos_db. All processing uses stage-0 values. Edges are detected against the previous stage-0 value.
- FSM states:
  - WAIT_INIT: the only state left by reset.
  - WAIT_INIT→WAIT_VS when cam_init_done=1.
  - WAIT_VS→SKIP on vsync rise, loading skip_cnt=SKIP_FRAMES. If SKIP_FRAMES=0, go directly to RUN.
  - SKIP: each vsync rise decrements skip_cnt. A rise seen with skip_cnt=1 enters RUN.
  - From any state, cam_init_done=0 returns the FSM to WAIT_INIT within one cycle and clears all counters.
- Entry to RUN happens on a vsync rise, so the first delivered frame is always complete.
- Beat assembly: byte_phase counts 0..PIX_BYTES-1 while href=1 and resets to 0 on href rise. On phase PIX_BYTES-1, the pixel is completed and line_px increments.
- Frame counting: line_no resets on vsync rise and increments on href fall. frame_cnt increments on vsync rise while in RUN (not on the entry rise).
- Crop: de=1 only in RUN for a completed pixel with WIN_X0 ≤ line_px < WIN_X0+WIN_W and WIN_Y0 ≤ line_no < WIN_Y0+WIN_H. pix_x = line_px−WIN_X0 and pix_y = line_no−WIN_Y0. Windows extending past H_ACTIVE are simply truncated.
- Line errors: on href fall in RUN, line_err pulses if byte_phase≠0 or line_px≠H_ACTIVE. The partial pixel is dropped.
- Mid-line events:
  - href fall mid-pixel: the partial pixel is dropped.
  - vsync rise while href=1: the line is abandoned, line_err pulses, and counters restart.

## Timing
- Reset values: state=WAIT_INIT, vsync=0, de=0, data=0, pix_x=0, pix_y=0, frame_cnt=0, line_err=0, err_sticky=0.
- Latency: the last beat of a pixel at the pins (captured at edge n) appears as de=1 with data valid after edge n+2. vsync output lags the pin by 2 cycles as well.
- de is never asserted in consecutive cycles when PIX_BYTES=2. It may be asserted every cycle when PIX_BYTES=1.
- `data`, `pix_x` and `pix_y` hold their value while de=0.
- There is no backpressure; the downstream block must accept every de.

## Test plan
- Reset, then cam_init_done=1 and 5 frames of 640×480 RGB565 with SKIP_FRAMES=3 → no de during frames 1–3; frame 4 gives 307200 de pulses; frame_cnt=1 after the frame-5 vsync.
- Bytes 0xF8,0x1F → de with data=16'hF81F exactly 2 cycles after the 0x1F beat; pix_x=0, pix_y=0.
- Crop WIN_X0=10, WIN_W=4, WIN_Y0=2, WIN_H=2 → 8 de per frame; pix_x runs 0..3 and pix_y runs 0..1.
- A line of 1279 bytes (odd) → line_err pulses once at href fall and err_sticky=1; 639 de on that line.
- cam_init_done dropped mid-frame → de=0 and vsync=0 within 1 cycle; after re-raise, SKIP_FRAMES frames are discarded again.
- DATA_W=10, PIX_BYTES=1 → one de per beat, data equal to the 10-bit input.

Source files
------------

// File: rtl/dvp_pixel_capture_if.sv
// Raw DVP sensor bus and the captured pixel stream of dvp_pixel_capture.
// The sensor drives the master side of dvp_sensor_if; the capture block drives dvp_pixel_if.
interface dvp_sensor_if #(
   parameter int DATA_W = 8
);
   logic              cmos_vsync;
   logic              cmos_href;
   logic [DATA_W-1:0] cmos_db;

   modport master (output cmos_vsync, cmos_href, cmos_db);
   modport slave  (input  cmos_vsync, cmos_href, cmos_db);
endinterface

interface dvp_pixel_if #(
   parameter int PIX_W = 16
);
   logic             vsync;
   logic             de;
   logic [PIX_W-1:0] data;
   logic [11:0]      pix_x;
   logic [11:0]      pix_y;

   modport master (output vsync, de, data, pix_x, pix_y);
   modport slave  (input  vsync, de, data, pix_x, pix_y);
endinterface

// File: rtl/dvp_pixel_capture.sv
// DVP camera capture: pin register, frame-skip FSM, beat assembly, crop window, line checks.
// Pipeline: stage 0 pins -> stage 1 assembly/counters -> stage 2 crop and outputs.
module dvp_pixel_capture #(
   parameter int   DATA_W      = 8,
   parameter int   PIX_BYTES   = 2,
   parameter int   H_ACTIVE    = 640,
   parameter int   SKIP_FRAMES = 3,
   parameter logic VS_POL      = 1'b1,
   parameter int   WIN_X0      = 0,
   parameter int   WIN_W       = 640,
   parameter int   WIN_Y0      = 0,
   parameter int   WIN_H       = 480
) (
   input  logic        cmos_pclk,
   input  logic        rst,
   input  logic        cam_init_done,
   dvp_sensor_if.slave sen,
   dvp_pixel_if.master pix,
   output logic [15:0] frame_cnt,
   output logic        line_err,
   output logic        err_sticky
);
   localparam int          PIX_W      = DATA_W * PIX_BYTES;
   localparam logic [2:0]  LAST_PHASE = 3'(PIX_BYTES - 1);
   localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
   localparam logic [3:0]  SKIP_N     = 4'(SKIP_FRAMES);
   localparam logic [12:0] X0_13      = 13'(WIN_X0);
   localparam logic [12:0] W_13       = 13'(WIN_W);
   localparam logic [12:0] Y0_13      = 13'(WIN_Y0);
   localparam logic [12:0] H_13       = 13'(WIN_H);

   typedef enum logic [1:0] {
      WAIT_INIT = 2'd0,
      WAIT_VS   = 2'd1,
      SKIP      = 2'd2,
      RUN       = 2'd3
   } state_t;

   logic              vs0_r, vs1_r, href0_r, href1_r;
   logic [DATA_W-1:0] db0_r;

   state_t            state_r;
   logic [3:0]        skip_cnt_r;
   logic [2:0]        byte_phase_r;
   logic [11:0]       line_px_r;
   logic [11:0]       line_no_r;
   logic              abandon_r;
   logic [PIX_W-1:0]  acc_r;
   logic              pix_done_r;
   logic [PIX_W-1:0]  pix_word_r;
   logic [11:0]       pix_col_r;
   logic [11:0]       pix_row_r;

   logic              vs_rise_s, href_rise_s, href_fall_s;
   logic [2:0]        phase_s;
   logic [11:0]       px_base_s;
   logic              beat_s, pix_last_s, line_err_s;
   logic [PIX_W-1:0]  acc_next_s;
   logic [12:0]       x_off_s, y_off_s;
   logic              in_win_s;

   // Stage 0: register the raw pins; vsync is normalised to active-high here
   always_ff @(posedge cmos_pclk or posedge rst) begin
      if (rst) begin
         vs0_r   <= 1'b0;
         vs1_r   <= 1'b0;
         href0_r <= 1'b0;
         href1_r <= 1'b0;
         db0_r   <= '0;
      end else begin
         vs0_r   <= (sen.cmos_vsync == VS_POL);
         vs1_r   <= vs0_r;
         href0_r <= sen.cmos_href;
         href1_r <= href0_r;
         db0_r   <= sen.cmos_db;
      end
   end

   assign vs_rise_s   = vs0_r & ~vs1_r;
   assign href_rise_s = href0_r & ~href1_r;
   assign href_fall_s = ~href0_r & href1_r;
   assign phase_s     = href_rise_s ? 3'd0 : byte_phase_r;
   assign px_base_s   = href_rise_s ? 12'd0 : line_px_r;
   // Beats of an abandoned line (vsync rose under href) are ignored until href drops
   assign beat_s      = href0_r & ~abandon_r & ~vs_rise_s;
   assign pix_last_s  = beat_s & (phase_s == LAST_PHASE);
   assign acc_next_s  = (acc_r << DATA_W) | PIX_W'(db0_r);

   assign line_err_s = (state_r == RUN) &
                       ((vs_rise_s & href0_r) |
                        (href_fall_s & ~vs_rise_s & ~abandon_r &
                         ((byte_phase_r != 3'd0) | (line_px_r != H_ACT))));

   // Stage 1: skip/run FSM, beat assembly, line and frame counters, line checks
   always_ff @(posedge cmos_pclk or posedge rst) begin
      if (rst) begin
         state_r      <= WAIT_INIT;
         skip_cnt_r   <= 4'd0;
         byte_phase_r <= 3'd0;
         line_px_r    <= 12'd0;
         line_no_r    <= 12'd0;
         abandon_r    <= 1'b0;
         acc_r        <= '0;
         pix_done_r   <= 1'b0;
         pix_word_r   <= '0;
         pix_col_r    <= 12'd0;
         pix_row_r    <= 12'd0;
         frame_cnt    <= 16'd0;
         line_err     <= 1'b0;
         err_sticky   <= 1'b0;
      end else if (!cam_init_done) begin
         state_r      <= WAIT_INIT;
         skip_cnt_r   <= 4'd0;
         byte_phase_r <= 3'd0;
         line_px_r    <= 12'd0;
         line_no_r    <= 12'd0;
         abandon_r    <= 1'b0;
         pix_done_r   <= 1'b0;
         frame_cnt    <= 16'd0;
         line_err     <= 1'b0;
         err_sticky   <= 1'b0;
      end else begin
         pix_done_r <= 1'b0;
         line_err   <= line_err_s;
         if (line_err_s) begin
            err_sticky <= 1'b1;
         end else begin
            err_sticky <= err_sticky;
         end

         if (beat_s) begin
            acc_r <= acc_next_s;
            if (pix_last_s) begin
               byte_phase_r <= 3'd0;
               line_px_r    <= px_base_s + 12'd1;
               pix_done_r   <= (state_r == RUN);
               pix_word_r   <= acc_next_s;
               pix_col_r    <= px_base_s;
               pix_row_r    <= line_no_r;
            end else begin
               byte_phase_r <= phase_s + 3'd1;
               line_px_r    <= px_base_s;
            end
         end

         // Line bookkeeping; a partial pixel left at href fall is simply dropped
         if (vs_rise_s) begin
            line_no_r    <= 12'd0;
            line_px_r    <= 12'd0;
            byte_phase_r <= 3'd0;
            abandon_r    <= href0_r;
         end else if (href_fall_s) begin
            if (!abandon_r) begin
               line_no_r <= line_no_r + 12'd1;
            end else begin
               line_no_r <= line_no_r;
            end
            abandon_r    <= 1'b0;
            line_px_r    <= 12'd0;
            byte_phase_r <= 3'd0;
         end

         case (state_r)
            WAIT_INIT: state_r <= WAIT_VS;
            WAIT_VS: begin
               if (vs_rise_s) begin
                  if (SKIP_N == 4'd0) begin
                     state_r <= RUN;
                  end else begin
                     state_r    <= SKIP;
                     skip_cnt_r <= SKIP_N;
                  end
               end
            end
            SKIP: begin
               if (vs_rise_s) begin
                  if (skip_cnt_r == 4'd1) begin
                     state_r <= RUN;
                  end else begin
                     skip_cnt_r <= skip_cnt_r - 4'd1;
                  end
               end
            end
            RUN: begin
               if (vs_rise_s) begin
                  frame_cnt <= frame_cnt + 16'd1;
               end
            end
            default: state_r <= WAIT_INIT;
         endcase
      end
   end

   // Offsets wrap to large values when left of/above the window, so one compare per axis suffices
   assign x_off_s  = {1'b0, pix_col_r} - X0_13;
   assign y_off_s  = {1'b0, pix_row_r} - Y0_13;
   assign in_win_s = (x_off_s < W_13) & (y_off_s < H_13);

   // Stage 2: crop and register outputs; dropping cam_init_done silences them on the next edge
   always_ff @(posedge cmos_pclk or posedge rst) begin
      if (rst) begin
         pix.vsync <= 1'b0;
         pix.de    <= 1'b0;
         pix.data  <= '0;
         pix.pix_x <= 12'd0;
         pix.pix_y <= 12'd0;
      end else if (!cam_init_done) begin
         pix.vsync <= 1'b0;
         pix.de    <= 1'b0;
      end else begin
         pix.vsync <= vs1_r & (state_r == RUN);
         pix.de    <= pix_done_r & in_win_s;
         if (pix_done_r & in_win_s) begin
            pix.data  <= pix_word_r;
            pix.pix_x <= x_off_s[11:0];
            pix.pix_y <= y_off_s[11:0];
         end
      end
   end

endmodule

// File: tb/tb_dvp_pixel_capture.sv
// Scoreboard bench: three capture instances (RGB565 full window, RGB565 cropped, 10-bit RAW)
// share one scripted sensor stream; the driver queues expected pixels, a monitor pops them.
module tb_dvp_pixel_capture;
   logic clk = 1'b0;
   logic rst;
   logic cam_init_done;
   always #5 clk = ~clk;

   dvp_sensor_if #(.DATA_W(8))  sen8 ();
   dvp_sensor_if #(.DATA_W(10)) sen10 ();
   dvp_pixel_if  #(.PIX_W(16))  pa ();
   dvp_pixel_if  #(.PIX_W(16))  pb ();
   dvp_pixel_if  #(.PIX_W(10))  pc ();

   assign sen10.cmos_vsync = sen8.cmos_vsync;
   assign sen10.cmos_href  = sen8.cmos_href;
   assign sen10.cmos_db    = {2'b10, sen8.cmos_db};

   logic [15:0] fc_a, fc_b, fc_c;
   logic        le_a, le_b, le_c, es_a, es_b, es_c;

   dvp_pixel_capture #(.DATA_W(8), .PIX_BYTES(2), .H_ACTIVE(16), .SKIP_FRAMES(3), .VS_POL(1'b1),
                       .WIN_X0(0), .WIN_W(16), .WIN_Y0(0), .WIN_H(480)) dut_a (
      .cmos_pclk(clk), .rst(rst), .cam_init_done(cam_init_done), .sen(sen8), .pix(pa),
      .frame_cnt(fc_a), .line_err(le_a), .err_sticky(es_a));

   dvp_pixel_capture #(.DATA_W(8), .PIX_BYTES(2), .H_ACTIVE(16), .SKIP_FRAMES(3), .VS_POL(1'b1),
                       .WIN_X0(10), .WIN_W(4), .WIN_Y0(2), .WIN_H(2)) dut_b (
      .cmos_pclk(clk), .rst(rst), .cam_init_done(cam_init_done), .sen(sen8), .pix(pb),
      .frame_cnt(fc_b), .line_err(le_b), .err_sticky(es_b));

   dvp_pixel_capture #(.DATA_W(10), .PIX_BYTES(1), .H_ACTIVE(32), .SKIP_FRAMES(0), .VS_POL(1'b1),
                       .WIN_X0(0), .WIN_W(32), .WIN_Y0(0), .WIN_H(480)) dut_c (
      .cmos_pclk(clk), .rst(rst), .cam_init_done(cam_init_done), .sen(sen10), .pix(pc),
      .frame_cnt(fc_c), .line_err(le_c), .err_sticky(es_c));

   typedef struct {
      logic [15:0] data;
      logic [11:0] x;
      logic [11:0] y;
      int          cyc;
   } exp_t;

   exp_t qa[$], qb[$], qc[$];
   int checks = 0, errors = 0;
   int cyc = 0;
   int frames_seen = 0;
   int de_cnt_a = 0, de_cnt_b = 0, de_cnt_c = 0;
   int le_cnt_a = 0, le_cnt_b = 0, le_cnt_c = 0;
   logic prev_de_a = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cmp_pix(input string nm, input exp_t e, input logic [15:0] d,
                          input logic [11:0] x, input logic [11:0] y);
      checks++;
      if (e.data !== d || e.x !== x || e.y !== y || e.cyc != cyc) begin
         errors++;
         $display("FAIL %s: got data=%h x=%0d y=%0d cyc=%0d expected data=%h x=%0d y=%0d cyc=%0d",
                  nm, d, x, y, cyc, e.data, e.x, e.y, e.cyc);
      end
   endtask

   task automatic unexpected(input string nm, input logic [15:0] d);
      checks++;
      errors++;
      $display("FAIL %s: got unexpected de data=%h at cyc=%0d expected no de", nm, d, cyc);
   endtask

   // Monitor: pop and compare on every de, count pulses
   always @(negedge clk) begin
      if (pa.de) begin
         de_cnt_a++;
         if (qa.size() == 0) unexpected("pix_a", pa.data);
         else cmp_pix("pix_a", qa.pop_front(), pa.data, pa.pix_x, pa.pix_y);
         checks++;
         if (prev_de_a) begin
            errors++;
            $display("FAIL de_a_spacing: got de in consecutive cycles at cyc=%0d expected gap", cyc);
         end
      end
      prev_de_a = pa.de;
      if (pb.de) begin
         de_cnt_b++;
         if (qb.size() == 0) unexpected("pix_b", pb.data);
         else cmp_pix("pix_b", qb.pop_front(), pb.data, pb.pix_x, pb.pix_y);
      end
      if (pc.de) begin
         de_cnt_c++;
         if (qc.size() == 0) unexpected("pix_c", {6'd0, pc.data});
         else cmp_pix("pix_c", qc.pop_front(), {6'd0, pc.data}, pc.pix_x, pc.pix_y);
      end
      if (le_a) le_cnt_a++;
      if (le_b) le_cnt_b++;
      if (le_c) le_cnt_c++;
   end

   // One href-high line; each line opens with bytes F8,1F so pixel 0 of A is 16'hF81F
   task automatic send_line(input int nbytes, input int line_idx, input bit keep_high);
      logic [7:0] b, first;
      first = 8'h00;
      for (int i = 0; i < nbytes; i++) begin
         @(negedge clk);
         b = (i == 0) ? 8'hF8 : (i == 1) ? 8'h1F : 8'(frames_seen * 37 + line_idx * 11 + i * 5);
         sen8.cmos_href = 1'b1;
         sen8.cmos_db   = b;
         if (i % 2 == 0) begin
            first = b;
         end else if (frames_seen > 3) begin
            qa.push_back('{data: {first, b}, x: 12'(i / 2), y: 12'(line_idx), cyc: cyc + 3});
            if (i / 2 >= 10 && i / 2 <= 13 && line_idx >= 2 && line_idx <= 3)
               qb.push_back('{data: {first, b}, x: 12'(i / 2 - 10), y: 12'(line_idx - 2), cyc: cyc + 3});
         end
         if (frames_seen > 0)
            qc.push_back('{data: {6'd0, 2'b10, b}, x: 12'(i), y: 12'(line_idx), cyc: cyc + 3});
      end
      if (!keep_high) begin
         @(negedge clk);
         sen8.cmos_href = 1'b0;
         sen8.cmos_db   = 8'h00;
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic send_vsync();
      @(negedge clk);
      sen8.cmos_vsync = 1'b1;
      frames_seen++;
      repeat (2) @(negedge clk);
      sen8.cmos_vsync = 1'b0;
      @(negedge clk);
      chk("vsync_a", {31'd0, pa.vsync}, {31'd0, frames_seen > 3});
      chk("vsync_c", {31'd0, pc.vsync}, {31'd0, frames_seen > 0});
      chk("frame_cnt_a", {16'd0, fc_a}, (frames_seen > 4) ? 32'(frames_seen - 4) : 32'd0);
      chk("frame_cnt_c", {16'd0, fc_c}, (frames_seen > 0) ? 32'(frames_seen - 1) : 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic send_frame(input int nlines, input int odd_line);
      send_vsync();
      for (int l = 0; l < nlines; l++) send_line((l == odd_line) ? 31 : 32, l, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected run to finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      cam_init_done = 1'b0;
      sen8.cmos_vsync = 1'b0;
      sen8.cmos_href  = 1'b0;
      sen8.cmos_db    = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_vsync", {31'd0, pa.vsync}, 32'd0);
      chk("rst_de", {31'd0, pa.de}, 32'd0);
      chk("rst_data", {16'd0, pa.data}, 32'd0);
      chk("rst_pix_x", {20'd0, pa.pix_x}, 32'd0);
      chk("rst_pix_y", {20'd0, pa.pix_y}, 32'd0);
      chk("rst_frame_cnt", {16'd0, fc_a}, 32'd0);
      chk("rst_line_err", {31'd0, le_a}, 32'd0);
      chk("rst_err_sticky", {31'd0, es_a}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      cam_init_done = 1'b1;
      repeat (3) @(negedge clk);

      // Frames 1-3 skipped on A/B, frame 4 delivered in full
      for (int f = 0; f < 4; f++) send_frame(4, -1);
      repeat (4) @(negedge clk);
      chk("de_count_a_f4", de_cnt_a, 32'd64);
      chk("de_count_b_f4", de_cnt_b, 32'd8);
      chk("err_sticky_a_clean", {31'd0, es_a}, 32'd0);

      // Frame 5: line 1 is 31 bytes long
      send_frame(4, 1);
      repeat (4) @(negedge clk);
      chk("de_count_a_f5", de_cnt_a, 32'd127);
      chk("de_count_b_f5", de_cnt_b, 32'd16);
      chk("line_err_a", le_cnt_a, 32'd1);
      chk("line_err_b", le_cnt_b, 32'd1);
      chk("line_err_c", le_cnt_c, 32'd1);
      chk("err_sticky_a", {31'd0, es_a}, 32'd1);

      // Frame 6: drop cam_init_done right before a pixel would appear
      send_vsync();
      send_line(4, 0, 1'b1);
      @(negedge clk);
      sen8.cmos_db = 8'h55;
      @(negedge clk);
      cam_init_done = 1'b0;
      @(posedge clk);
      #1;
      chk("drop_de_a", {31'd0, pa.de}, 32'd0);
      chk("drop_de_c", {31'd0, pc.de}, 32'd0);
      chk("drop_vsync_a", {31'd0, pa.vsync}, 32'd0);
      while (qa.size() > 0 && qa[$].cyc >= cyc) void'(qa.pop_back());
      while (qb.size() > 0 && qb[$].cyc >= cyc) void'(qb.pop_back());
      while (qc.size() > 0 && qc[$].cyc >= cyc) void'(qc.pop_back());
      @(negedge clk);
      sen8.cmos_href = 1'b0;
      sen8.cmos_db   = 8'h00;
      repeat (4) @(negedge clk);
      chk("drop_frame_cnt_a", {16'd0, fc_a}, 32'd0);
      chk("drop_frame_cnt_c", {16'd0, fc_c}, 32'd0);
      chk("drop_err_sticky_a", {31'd0, es_a}, 32'd0);

      // Re-raise: three frames skipped again, the fourth delivered
      cam_init_done = 1'b1;
      frames_seen = 0;
      repeat (3) @(negedge clk);
      for (int f = 0; f < 4; f++) send_frame(4, -1);
      repeat (4) @(negedge clk);
      chk("de_count_a_end", de_cnt_a, 32'd192);
      chk("de_count_b_end", de_cnt_b, 32'd24);
      chk("queue_a_empty", qa.size(), 32'd0);
      chk("queue_b_empty", qb.size(), 32'd0);
      chk("queue_c_empty", qc.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
